// File: rtl/pp_udiv_pkg.sv
// pp_udiv_pkg
// Shared definitions for the iterative unsigned divider:
//   - udiv_state_t : divider FSM states (IDLE / CALC / DONE)
//   - UDIV_DIVIDEND_W / UDIV_DIVISOR_W / UDIV_CNT_W : default widths
//   - UDIV_DBZ_QUOT : quotient reported for a zero divisor (all ones)
package pp_udiv_pkg;

  typedef enum logic [1:0] {
    UDIV_IDLE = 2'd0,
    UDIV_CALC = 2'd1,
    UDIV_DONE = 2'd2
  } udiv_state_t;

  localparam int UDIV_DIVIDEND_W = 22;
  localparam int UDIV_DIVISOR_W  = 11;
  localparam int UDIV_CNT_W      = 5;

  localparam logic [UDIV_DIVIDEND_W-1:0] UDIV_DBZ_QUOT = '1;

endpackage

// File: rtl/pp_pipeline_accel_udiv_22ns_11ns_seq_if.sv
// pp_pipeline_accel_udiv_22ns_11ns_seq_if
// Operand/result handshake bundle of the divider.
//   in_valid/in_ready   : operand pair handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder)
// Modports:
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : divider side (drives in_ready and the result)
interface pp_pipeline_accel_udiv_22ns_11ns_seq_if
  import pp_udiv_pkg::*;
#(
  parameter int DIVIDEND_W = UDIV_DIVIDEND_W,
  parameter int DIVISOR_W  = UDIV_DIVISOR_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/pp_udiv_step.sv
// pp_udiv_step
// One restoring-division iteration, purely combinational.
//   r_in    : current partial remainder (always < divisor)
//   bit_in  : next dividend bit, MSB first
//   divisor : divisor
//   r_out   : next partial remainder
//   qbit    : quotient bit produced by this iteration
// The trial value T = {r_in, bit_in} is one bit wider than the divisor. The
// next remainder always fits in DIVISOR_W bits (it is either T when T < divisor,
// or T - divisor < divisor), so the subtraction is done modulo 2**DIVISOR_W.
module pp_udiv_step #(
  parameter int DIVISOR_W = 11
) (
  input  logic [DIVISOR_W-1:0] r_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] r_out,
  output logic                 qbit
);
  logic [DIVISOR_W:0] trial;

  assign trial = {r_in, bit_in};
  assign qbit  = (trial >= {1'b0, divisor});
  assign r_out = qbit ? (trial[DIVISOR_W-1:0] - divisor) : trial[DIVISOR_W-1:0];
endmodule

// File: rtl/pp_pipeline_accel_udiv_22ns_11ns_seq.sv
// pp_pipeline_accel_udiv_22ns_11ns_seq
// Iterative unsigned restoring divider: 22-bit dividend / 11-bit divisor ->
// 22-bit quotient and 11-bit remainder, one quotient bit per clock, MSB first.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   ce          : clock enable; low freezes all state (handshakes stall)
//   bus         : slave side of the operand/result handshake interface
//   div_by_zero : (only with PP_UDIV_DBZ_FLAG_EN) high in DONE when the
//                 latched divisor was zero
// Optional feature macro: PP_UDIV_DBZ_FLAG_EN.
// A zero divisor skips iteration and reports quotient = all ones,
// remainder = low DIVISOR_W bits of the dividend.
// CNT_W must satisfy 2**CNT_W > DIVIDEND_W.
module pp_pipeline_accel_udiv_22ns_11ns_seq
  import pp_udiv_pkg::*;
#(
  parameter int DIVIDEND_W = UDIV_DIVIDEND_W,
  parameter int DIVISOR_W  = UDIV_DIVISOR_W,
  parameter int CNT_W      = UDIV_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
`ifdef PP_UDIV_DBZ_FLAG_EN
  output logic div_by_zero,
`endif
  pp_pipeline_accel_udiv_22ns_11ns_seq_if.slave bus
);
  localparam logic [DIVIDEND_W-1:0] DBZ_QUOT = '1;
  localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(DIVIDEND_W - 1);

  udiv_state_t state_q, state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;

  logic                  in_ready;
  logic                  out_valid;
  logic                  load;
  logic                  step_en;
  logic [DIVISOR_W-1:0]  rem_nxt;
  logic                  qbit;

  // Next state and handshake outputs. ce gates every transition, so with
  // ce low state_d equals state_q and no handshake completes.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step_en   = 1'b0;
    case (state_q)
      UDIV_IDLE: begin
        in_ready = 1'b1;
        if (ce && bus.in_valid) begin
          load    = 1'b1;
          state_d = (bus.divisor == '0) ? UDIV_DONE : UDIV_CALC;
        end
      end
      UDIV_CALC: begin
        step_en = ce;
        if (ce && (cnt_q == '0)) begin
          state_d = UDIV_DONE;
        end
      end
      UDIV_DONE: begin
        out_valid = 1'b1;
        if (ce && bus.out_ready) begin
          state_d = UDIV_IDLE;
        end
      end
      default: begin
        state_d = UDIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UDIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Iteration datapath: the dividend shifts out MSB first while quotient bits
  // shift in at the LSB. The remainder register doubles as the partial
  // remainder R; its top bit is always zero so it is not stored.
  pp_udiv_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .r_in    (rem_q),
    .bit_in  (dvd_q[DIVIDEND_W-1]),
    .divisor (dvs_q),
    .r_out   (rem_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_INIT;
      if (bus.divisor == '0) begin
        quo_q <= DBZ_QUOT;
        rem_q <= bus.dividend[DIVISOR_W-1:0];
      end else begin
        quo_q <= '0;
        rem_q <= '0;
      end
    end else if (step_en) begin
      quo_q <= {quo_q[DIVIDEND_W-2:0], qbit};
      rem_q <= rem_nxt;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Operand registers carry no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    if (load) begin
      dvd_q <= bus.dividend;
      dvs_q <= bus.divisor;
    end else if (step_en) begin
      dvd_q <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
    end
  end

`ifdef PP_UDIV_DBZ_FLAG_EN
  logic dbz_q;

  // A zero divisor goes straight from IDLE to DONE, so the flag is set on the
  // accepting edge and dropped on the edge that leaves DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_q <= 1'b0;
    end else if (load) begin
      dbz_q <= (bus.divisor == '0);
    end else if ((state_q == UDIV_DONE) && (state_d != UDIV_DONE)) begin
      dbz_q <= 1'b0;
    end
  end

  assign div_by_zero = dbz_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_pp_pipeline_accel_udiv_22ns_11ns_seq.sv
// tb_pp_pipeline_accel_udiv_22ns_11ns_seq
// Directed vector table plus hand-written sequences for backpressure, ce
// stalls and mid-operation reset. Build with +define+PP_UDIV_DBZ_FLAG_EN to
// also cover the div_by_zero flag.
module tb_pp_pipeline_accel_udiv_22ns_11ns_seq;
  import pp_udiv_pkg::*;

  logic clk;
  logic rst_n;
  logic ce;
`ifdef PP_UDIV_DBZ_FLAG_EN
  logic div_by_zero;
`endif

  pp_pipeline_accel_udiv_22ns_11ns_seq_if bus ();

  pp_pipeline_accel_udiv_22ns_11ns_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
`ifdef PP_UDIV_DBZ_FLAG_EN
    .div_by_zero (div_by_zero),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] dvd;
    logic [10:0] dvs;
    logic [21:0] exp_q;
    logic [10:0] exp_r;
    int          exp_lat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Presents one operand pair in IDLE and waits (bounded) for out_valid.
  // lat counts edges from the accepting edge inclusive.
  task automatic start_op(input logic [21:0] dvd, input logic [10:0] dvs,
                          output int lat, output logic [21:0] q, output logic [10:0] r);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = bus.quotient;
    r = bus.remainder;
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("out_valid_after_handshake", {31'd0, bus.out_valid}, 32'd0);
    check("in_ready_after_handshake", {31'd0, bus.in_ready}, 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    int          lat;
    logic [21:0] q;
    logic [10:0] r;
    int          held;
    int          seen;

    vecs[0] = '{22'd1000000, 11'd7,    22'd142857,  11'd1,    23};
    vecs[1] = '{22'd4194303, 11'd2047, 22'd2049,    11'd0,    23};
    vecs[2] = '{22'd5,       11'd10,   22'd0,       11'd5,    23};
    vecs[3] = '{22'd1234,    11'd0,    22'h3FFFFF,  11'd1234, 1};
    vecs[4] = '{22'd100,     11'd3,    22'd33,      11'd1,    23};
    vecs[5] = '{22'd0,       11'd5,    22'd0,       11'd0,    23};
    vecs[6] = '{22'd4194303, 11'd1,    22'd4194303, 11'd0,    23};
    vecs[7] = '{22'd3000000, 11'd0,    22'h3FFFFF,  11'h6C0,  1};

    rst_n         = 1'b0;
    ce            = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_quotient", {10'd0, bus.quotient}, 32'd0);
    check("reset_remainder", {21'd0, bus.remainder}, 32'd0);
`ifdef PP_UDIV_DBZ_FLAG_EN
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].dvd, vecs[i].dvs, lat, q, r);
      check($sformatf("vec%0d_quotient", i), {10'd0, q}, {10'd0, vecs[i].exp_q});
      check($sformatf("vec%0d_remainder", i), {21'd0, r}, {21'd0, vecs[i].exp_r});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
`ifdef PP_UDIV_DBZ_FLAG_EN
      check($sformatf("vec%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, (vecs[i].dvs == 11'd0)});
`endif
      finish_op();
`ifdef PP_UDIV_DBZ_FLAG_EN
      check($sformatf("vec%0d_dbz_cleared", i), {31'd0, div_by_zero}, 32'd0);
`endif
    end

    // Backpressure: hold DONE for 10 cycles with stray in_valid pulses
    start_op(22'd1000000, 11'd7, lat, q, r);
    check("bp_latency", lat, 23);
    held = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_valid = c[0];
      bus.dividend = 22'd9;
      bus.divisor  = 11'd3;
      @(posedge clk);
      #1;
      if (bus.out_valid && !bus.in_ready && bus.quotient == 22'd142857 && bus.remainder == 11'd1)
        held++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_hold_cycles", held, 10);
    finish_op();
    start_op(22'd100, 11'd3, lat, q, r);
    check("bp_next_quotient", {10'd0, q}, 32'd33);
    check("bp_next_remainder", {21'd0, r}, 32'd1);
    check("bp_next_latency", lat, 23);

    // ce low in DONE with out_ready high: no handshake
    @(negedge clk);
    ce = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ce_low_done_out_valid", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk);
    ce = 1'b1;
    bus.out_ready = 1'b0;
    finish_op();

    // ce low for 5 cycles mid-CALC
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 22'd1000000;
    bus.divisor  = 11'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      ce = (lat >= 5 && lat < 10) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    ce = 1'b1;
    check("stall_latency", lat, 28);
    check("stall_quotient", {10'd0, bus.quotient}, 32'd142857);
    check("stall_remainder", {21'd0, bus.remainder}, 32'd1);
    finish_op();

    // ce low in IDLE with in_valid high: nothing accepted
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ce = 1'b0;
      bus.in_valid = 1'b1;
      bus.dividend = 22'd50;
      bus.divisor  = 11'd0;
      @(posedge clk);
      #1;
      if (bus.out_valid || !bus.in_ready) seen++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    ce = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || !bus.in_ready) seen++;
    end
    check("ce_low_idle_no_accept", seen, 0);

    // Reset pulsed at CALC iteration 10
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 22'd1000000;
    bus.divisor  = 11'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midcalc_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midcalc_rst_quotient", {10'd0, bus.quotient}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("midcalc_rst_no_out_valid", seen, 0);
    start_op(22'd100, 11'd3, lat, q, r);
    check("post_rst_quotient", {10'd0, q}, 32'd33);
    check("post_rst_remainder", {21'd0, r}, 32'd1);
    check("post_rst_latency", lat, 23);
    finish_op();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
